// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV32M multiply/divide sequencer beside the EX-stage ALU
module muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            muldiv_start_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] op_a_E,
  input  logic [XLEN-1:0] op_b_E,
  input  logic            Flush,
  output logic            muldiv_stall,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result,
  output logic            muldiv_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q;      // {hi, lo}: product, or {remainder, dividend/quotient}
  logic                neg_q;      // negate selected result at DONE

  logic                is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_by_zero, div_ovf, special, start_ok;
  logic [2*XLEN-1:0]   special_acc;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, mul_full;
  logic [XLEN-1:0]     mul_sel, div_raw, div_sel, final_res;

  // Operand decode: signedness, magnitudes and divide fast-path detection
  always_comb begin
    is_div      = funct3_E[2];
    a_signed    = is_div ? !funct3_E[0] : (funct3_E[1:0] != 2'b11);
    b_signed    = is_div ? !funct3_E[0] : !funct3_E[1];
    a_neg       = a_signed & op_a_E[XLEN-1];
    b_neg       = b_signed & op_b_E[XLEN-1];
    a_mag       = a_neg ? -op_a_E : op_a_E;
    b_mag       = b_neg ? -op_b_E : op_b_E;
    div_by_zero = (op_b_E == '0);
    div_ovf     = !funct3_E[0] && (op_a_E == INT_MIN) && (op_b_E == '1);
    special     = is_div & (div_by_zero | div_ovf);
    // Fast-path results are placed where the normal result select will find them
    if (div_by_zero)
      special_acc = funct3_E[1] ? {op_a_E, {XLEN{1'b0}}} : {{XLEN{1'b0}}, {XLEN{1'b1}}};
    else
      special_acc = funct3_E[1] ? {2*XLEN{1'b0}} : {{XLEN{1'b0}}, op_a_E};
    start_ok    = (state_q == S_IDLE) && muldiv_start_E && !Flush;
  end

  // One shift-add multiply step and one restoring-divide step
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[XLEN])
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and field select of the finished result
  always_comb begin
    mul_full  = neg_q ? -acc_q : acc_q;
    mul_sel   = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    div_raw   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_sel   = neg_q ? -div_raw : div_raw;
    final_res = f3_q[2] ? div_sel : mul_sel;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and outputs; Flush overrides everything, start is ignored outside IDLE
  always_comb begin
    state_d       = state_q;
    muldiv_stall  = 1'b0;
    muldiv_done   = 1'b0;
    muldiv_result = '0;
    muldiv_busy   = (state_q != S_IDLE);
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (muldiv_start_E) state_d = special ? S_DONE : S_BUSY;
        S_BUSY: if (cnt_q == CNT_LAST) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    muldiv_stall = i_reset & (start_ok | (state_q == S_BUSY));
    if (state_q == S_DONE && !Flush) begin
      muldiv_done   = 1'b1;
      muldiv_result = final_res;
    end
  end

  // Operand latch, iteration datapath and step counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      f3_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
    end else if (start_ok) begin
      cnt_q <= '0;
      f3_q  <= funct3_E;
      if (special) begin
        opnd_q <= '0;
        acc_q  <= special_acc;
        neg_q  <= 1'b0;
      end else if (is_div) begin
        opnd_q <= b_mag;
        acc_q  <= {{XLEN{1'b0}}, a_mag};
        neg_q  <= funct3_E[1] ? a_neg : (a_neg ^ b_neg);
      end else begin
        opnd_q <= a_mag;
        acc_q  <= {{XLEN{1'b0}}, b_mag};
        neg_q  <= a_neg ^ b_neg;
      end
    end else if (state_q == S_BUSY && !Flush) begin
      acc_q <= f3_q[2] ? div_next : mul_next;
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        muldiv_start_E = 1'b0;
  logic [2:0]  funct3_E = 3'd0;
  logic [31:0] op_a_E = '0;
  logic [31:0] op_b_E = '0;
  logic        Flush = 1'b0;
  logic        muldiv_stall, muldiv_done, muldiv_busy;
  logic [31:0] muldiv_result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b1;

  muldiv_ctrl #(.XLEN(32)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .muldiv_start_E(muldiv_start_E),
    .funct3_E(funct3_E),
    .op_a_E(op_a_E),
    .op_b_E(op_b_E),
    .Flush(Flush),
    .muldiv_stall(muldiv_stall),
    .muldiv_done(muldiv_done),
    .muldiv_result(muldiv_result),
    .muldiv_busy(muldiv_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, in value and cycle
  initial begin
    forever begin
      @(negedge i_clk);
      if (mon_on && muldiv_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(muldiv_done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, "_result"}, muldiv_result, e.res);
          chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic wait_done(input string name, input int stall_exp);
    int sc = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge i_clk);
      if (muldiv_done === 1'b1) seen = 1'b1;
      else if (muldiv_stall === 1'b1) sc++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_stall_cycles"}, 32'(sc), 32'(stall_exp));
  endtask

  // Issue one op in the cycle after the previous call; start stays high until done
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    @(posedge i_clk); #1;
    muldiv_start_E = 1'b1;
    funct3_E = f3;
    op_a_E = a;
    op_b_E = b;
    e.res = exp; e.cyc = cyc + lat; e.name = name;
    exp_q.push_back(e);
    wait_done(name, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_stall", 32'(muldiv_stall), 32'd0);
    chk("rst_done", 32'(muldiv_done), 32'd0);
    chk("rst_result", muldiv_result, 32'd0);
    chk("rst_busy", 32'(muldiv_busy), 32'd0);
    i_reset = 1'b1;

    // Multiply family, back-to-back
    run_op("mul_7_m3",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu_m1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu_m1",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    // Divide family
    run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,        33);
    // Fast paths
    run_op("divu_by0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_by0",   3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush mid-divide: no done, stall drops the next cycle
    @(posedge i_clk); #1;
    muldiv_start_E = 1'b1; funct3_E = 3'b101; op_a_E = 32'd100; op_b_E = 32'd7;
    repeat (10) @(posedge i_clk);
    #1;
    Flush = 1'b1; muldiv_start_E = 1'b0;
    @(posedge i_clk); #1;
    Flush = 1'b0;
    chk("flush_stall_next", 32'(muldiv_stall), 32'd0);
    chk("flush_busy_next", 32'(muldiv_busy), 32'd0);
    repeat (40) @(negedge i_clk);
    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Flush and start together in IDLE: start ignored
    @(posedge i_clk); #1;
    muldiv_start_E = 1'b1; Flush = 1'b1; funct3_E = 3'b000; op_a_E = 32'd9; op_b_E = 32'd9;
    #1;
    chk("flush_start_stall", 32'(muldiv_stall), 32'd0);
    @(posedge i_clk); #1;
    muldiv_start_E = 1'b0; Flush = 1'b0;
    chk("flush_start_busy", 32'(muldiv_busy), 32'd0);

    // Reset mid-multiply, then start held high gives a fresh full-latency result
    @(posedge i_clk); #1;
    muldiv_start_E = 1'b1; funct3_E = 3'b000; op_a_E = 32'd5; op_b_E = 32'd6;
    repeat (5) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(muldiv_stall), 32'd0);
    chk("midrst_done", 32'(muldiv_done), 32'd0);
    chk("midrst_result", muldiv_result, 32'd0);
    chk("midrst_busy", 32'(muldiv_busy), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    e.res = 32'd30; e.cyc = cyc + 33; e.name = "mul_after_rst";
    exp_q.push_back(e);
    wait_done("mul_after_rst", 32);

    @(posedge i_clk); #1;
    muldiv_start_E = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
